// File: rtl/wm_plant_emulator.sv
// Washing-machine plant model: water level, temperature, drum speed and door latch
// advance on a prescaled physics tick and drive registered sensor outputs.
module wm_plant_emulator #(
  parameter logic [15:0] TICK_DIV       = 16'd4,
  parameter logic [9:0]  FILL_RATE      = 10'd8,
  parameter logic [9:0]  DRAIN_RATE     = 10'd12,
  parameter logic [9:0]  MAX_LEVEL      = 10'd1000,
  parameter logic [9:0]  MIN_HEAT_LEVEL = 10'd80,
  parameter logic [7:0]  HEAT_DIV       = 8'd3,
  parameter logic [7:0]  COOL_DIV       = 8'd20,
  parameter logic [6:0]  AMBIENT_TEMP   = 7'd15,
  parameter logic [6:0]  TEMP_MAX       = 7'd95,
  parameter logic [9:0]  MOTOR_ACCEL    = 10'd20,
  parameter logic [9:0]  MOTOR_DECEL    = 10'd10,
  parameter logic [9:0]  MOTOR_MAX      = 10'd700,
  parameter logic [9:0]  VIB_SPEED      = 10'd300,
  parameter logic [7:0]  LOCK_DELAY     = 8'd5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       water_valve,
  input  logic       heater,
  input  logic       drain_pump,
  input  logic       drum_motor,
  input  logic       door_lock,
  input  logic       imbalance_inject,
  input  logic       sensor_freeze,
  output logic [9:0] water_level_sensor,
  output logic [6:0] temperature_adc_sensor,
  output logic [9:0] motor_speed_sensor,
  output logic       vibration_sensor,
  output logic       door_locked,
  output logic       overflow_flag,
  output logic       dry_heat_fault
);

  typedef enum logic [1:0] {S_UNLOCKED, S_LOCKING, S_LOCKED, S_UNLOCKING} door_t;

  door_t              r_door, w_door_next;
  logic [15:0]        r_presc;
  logic               w_tick;
  logic [9:0]         r_level, w_level_next;
  logic signed [10:0] w_lvl_sum;
  logic [6:0]         r_temp, w_temp_next;
  logic [7:0]         r_heat_cnt, w_heat_cnt_next;
  logic [7:0]         r_cool_cnt, w_cool_cnt_next;
  logic [9:0]         r_speed, w_speed_next;
  logic [10:0]        w_speed_sum;
  logic [7:0]         r_lock_cnt, w_lock_cnt_next;
  logic               w_locked_int, w_locked_next, w_heating;

  assign w_tick        = (r_presc == TICK_DIV - 16'd1);
  assign w_locked_int  = (r_door == S_LOCKED) || (r_door == S_UNLOCKING);
  assign w_locked_next = (w_door_next == S_LOCKED) || (w_door_next == S_UNLOCKING);
  assign w_heating     = heater && (r_level >= MIN_HEAT_LEVEL);

  always_comb begin
    w_lvl_sum = $signed({1'b0, r_level})
              + (water_valve ? $signed({1'b0, FILL_RATE})  : 11'sd0)
              - (drain_pump  ? $signed({1'b0, DRAIN_RATE}) : 11'sd0);
    if (w_lvl_sum < 11'sd0)
      w_level_next = '0;
    else if (w_lvl_sum > $signed({1'b0, MAX_LEVEL}))
      w_level_next = MAX_LEVEL;
    else
      w_level_next = w_lvl_sum[9:0];
  end

  // An empty drum resets the water to inlet temperature, overriding heat/cool.
  always_comb begin
    w_temp_next     = r_temp;
    w_heat_cnt_next = r_heat_cnt;
    w_cool_cnt_next = r_cool_cnt;
    if (w_level_next == '0) begin
      w_temp_next     = AMBIENT_TEMP;
      w_heat_cnt_next = '0;
      w_cool_cnt_next = '0;
    end else if (w_heating) begin
      w_cool_cnt_next = '0;
      if (r_heat_cnt == HEAT_DIV - 8'd1) begin
        w_heat_cnt_next = '0;
        if (r_temp < TEMP_MAX) w_temp_next = r_temp + 7'd1;
      end else begin
        w_heat_cnt_next = r_heat_cnt + 8'd1;
      end
    end else begin
      w_heat_cnt_next = '0;
      if (r_cool_cnt == COOL_DIV - 8'd1) begin
        w_cool_cnt_next = '0;
        if (r_temp > AMBIENT_TEMP) w_temp_next = r_temp - 7'd1;
      end else begin
        w_cool_cnt_next = r_cool_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_speed_sum = {1'b0, r_speed} + {1'b0, MOTOR_ACCEL};
    if (drum_motor && w_locked_int)
      w_speed_next = (w_speed_sum > {1'b0, MOTOR_MAX}) ? MOTOR_MAX : w_speed_sum[9:0];
    else
      w_speed_next = (r_speed < MOTOR_DECEL) ? '0 : r_speed - MOTOR_DECEL;
  end

  // The transition tick itself counts as the first latch tick in either direction.
  always_comb begin
    w_door_next     = r_door;
    w_lock_cnt_next = r_lock_cnt;
    case (r_door)
      S_UNLOCKED: if (door_lock) begin
        w_door_next     = S_LOCKING;
        w_lock_cnt_next = 8'd1;
      end
      S_LOCKING: begin
        if (!door_lock) begin
          w_door_next     = S_UNLOCKED;
          w_lock_cnt_next = '0;
        end else if (r_lock_cnt + 8'd1 >= LOCK_DELAY) begin
          w_door_next     = S_LOCKED;
          w_lock_cnt_next = '0;
        end else begin
          w_lock_cnt_next = r_lock_cnt + 8'd1;
        end
      end
      S_LOCKED: if (!door_lock && r_speed == '0 && r_level == '0) begin
        w_door_next     = S_UNLOCKING;
        w_lock_cnt_next = 8'd1;
      end
      S_UNLOCKING: begin
        if (door_lock) begin
          w_door_next     = S_LOCKED;
          w_lock_cnt_next = '0;
        end else if (r_lock_cnt + 8'd1 >= LOCK_DELAY) begin
          w_door_next     = S_UNLOCKED;
          w_lock_cnt_next = '0;
        end else begin
          w_lock_cnt_next = r_lock_cnt + 8'd1;
        end
      end
      default: begin
        w_door_next     = S_UNLOCKED;
        w_lock_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc                <= '0;
      r_level                <= '0;
      r_temp                 <= AMBIENT_TEMP;
      r_heat_cnt             <= '0;
      r_cool_cnt             <= '0;
      r_speed                <= '0;
      r_lock_cnt             <= '0;
      r_door                 <= S_UNLOCKED;
      water_level_sensor     <= '0;
      temperature_adc_sensor <= AMBIENT_TEMP;
      motor_speed_sensor     <= '0;
      vibration_sensor       <= 1'b0;
      door_locked            <= 1'b0;
      overflow_flag          <= 1'b0;
      dry_heat_fault         <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 16'd1;
      if (w_tick) begin
        r_level    <= w_level_next;
        r_temp     <= w_temp_next;
        r_heat_cnt <= w_heat_cnt_next;
        r_cool_cnt <= w_cool_cnt_next;
        r_speed    <= w_speed_next;
        r_door     <= w_door_next;
        r_lock_cnt <= w_lock_cnt_next;
        if (water_valve && r_level == MAX_LEVEL) overflow_flag  <= 1'b1;
        if (heater && r_level < MIN_HEAT_LEVEL)  dry_heat_fault <= 1'b1;
        if (!sensor_freeze) begin
          water_level_sensor     <= w_level_next;
          temperature_adc_sensor <= w_temp_next;
          motor_speed_sensor     <= w_speed_next;
          vibration_sensor       <= imbalance_inject && (w_speed_next >= VIB_SPEED);
          door_locked            <= w_locked_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_wm_plant_emulator.sv
// Directed closed-loop scenarios for wm_plant_emulator with hand-computed sensor values.
module tb_wm_plant_emulator;

  localparam int unsigned TDIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       water_valve = 1'b0, heater = 1'b0, drain_pump = 1'b0, drum_motor = 1'b0;
  logic       door_lock = 1'b0, imbalance_inject = 1'b0, sensor_freeze = 1'b0;
  logic [9:0] water_level_sensor, motor_speed_sensor;
  logic [6:0] temperature_adc_sensor;
  logic       vibration_sensor, door_locked, overflow_flag, dry_heat_fault;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  wm_plant_emulator #(.TICK_DIV(16'(TDIV))) dut (
    .clk                    (clk),
    .reset                  (reset),
    .water_valve            (water_valve),
    .heater                 (heater),
    .drain_pump             (drain_pump),
    .drum_motor             (drum_motor),
    .door_lock              (door_lock),
    .imbalance_inject       (imbalance_inject),
    .sensor_freeze          (sensor_freeze),
    .water_level_sensor     (water_level_sensor),
    .temperature_adc_sensor (temperature_adc_sensor),
    .motor_speed_sensor     (motor_speed_sensor),
    .vibration_sensor       (vibration_sensor),
    .door_locked            (door_locked),
    .overflow_flag          (overflow_flag),
    .dry_heat_fault         (dry_heat_fault)
  );

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance a whole number of physics ticks, then settle just past the last edge.
  task automatic run_ticks(input int unsigned n);
    repeat (n * TDIV) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_level", water_level_sensor, 0);
    check_eq("rst_temp", temperature_adc_sensor, 15);
    check_eq("rst_speed", motor_speed_sensor, 0);
    check_eq("rst_vib", vibration_sensor, 0);
    check_eq("rst_locked", door_locked, 0);
    check_eq("rst_ovf", overflow_flag, 0);
    check_eq("rst_dry", dry_heat_fault, 0);
    reset = 1'b0;

    // Fill, heat, fill to the brim, overflow, drain back to empty.
    water_valve = 1'b1;
    run_ticks(10);  check_eq("fill_10", water_level_sensor, 80);
    run_ticks(15);  check_eq("fill_25", water_level_sensor, 200);
    water_valve = 1'b0; heater = 1'b1;
    run_ticks(30);
    check_eq("heat_temp", temperature_adc_sensor, 25);
    check_eq("heat_level", water_level_sensor, 200);
    check_eq("heat_nodry", dry_heat_fault, 0);
    heater = 1'b0; water_valve = 1'b1;
    run_ticks(100);
    check_eq("full_level", water_level_sensor, 1000);
    check_eq("full_cooled", temperature_adc_sensor, 20);
    check_eq("full_noovf", overflow_flag, 0);
    run_ticks(1);
    check_eq("ovf_set", overflow_flag, 1);
    check_eq("ovf_level", water_level_sensor, 1000);
    water_valve = 1'b0; drain_pump = 1'b1;
    run_ticks(83);
    check_eq("drain_83", water_level_sensor, 4);
    check_eq("drain_83_temp", temperature_adc_sensor, 16);
    run_ticks(1);
    check_eq("drain_clamp", water_level_sensor, 0);
    check_eq("drain_ambient", temperature_adc_sensor, 15);
    drain_pump = 1'b0;

    // Heater on a near-empty drum.
    water_valve = 1'b1;
    run_ticks(6);   check_eq("low_fill", water_level_sensor, 48);
    water_valve = 1'b0; heater = 1'b1;
    run_ticks(5);
    check_eq("dry_fault", dry_heat_fault, 1);
    check_eq("dry_temp", temperature_adc_sensor, 15);
    heater = 1'b0; drain_pump = 1'b1;
    run_ticks(4);   check_eq("low_drain", water_level_sensor, 0);
    drain_pump = 1'b0;

    // Door latch, motor ramp, vibration and the speed interlock.
    drum_motor = 1'b1;
    run_ticks(3);
    check_eq("unlk_speed", motor_speed_sensor, 0);
    check_eq("unlk_locked", door_locked, 0);
    door_lock = 1'b1;
    run_ticks(4);   check_eq("lock_4", door_locked, 0);
    run_ticks(1);
    check_eq("lock_5", door_locked, 1);
    check_eq("lock_speed", motor_speed_sensor, 0);
    imbalance_inject = 1'b1;
    run_ticks(14);
    check_eq("spd_280", motor_speed_sensor, 280);
    check_eq("vib_280", vibration_sensor, 0);
    run_ticks(1);
    check_eq("spd_300", motor_speed_sensor, 300);
    check_eq("vib_300", vibration_sensor, 1);
    run_ticks(20);  check_eq("spd_max", motor_speed_sensor, 700);
    run_ticks(1);   check_eq("spd_sat", motor_speed_sensor, 700);
    door_lock = 1'b0; drum_motor = 1'b0;
    run_ticks(1);
    check_eq("decel_1", motor_speed_sensor, 690);
    check_eq("interlock_1", door_locked, 1);
    run_ticks(69);
    check_eq("decel_stop", motor_speed_sensor, 0);
    check_eq("interlock_0", door_locked, 1);
    check_eq("vib_stop", vibration_sensor, 0);
    run_ticks(4);   check_eq("unlock_4", door_locked, 1);
    run_ticks(1);   check_eq("unlock_5", door_locked, 0);
    imbalance_inject = 1'b0;

    // Sensor freeze during filling, then reset mid-fill.
    water_valve = 1'b1;
    run_ticks(5);   check_eq("frz_pre", water_level_sensor, 40);
    sensor_freeze = 1'b1;
    run_ticks(5);   check_eq("frz_hold", water_level_sensor, 40);
    sensor_freeze = 1'b0;
    run_ticks(1);   check_eq("frz_release", water_level_sensor, 88);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_level", water_level_sensor, 0);
    check_eq("mid_rst_temp", temperature_adc_sensor, 15);
    check_eq("mid_rst_ovf", overflow_flag, 0);
    check_eq("mid_rst_dry", dry_heat_fault, 0);
    check_eq("mid_rst_locked", door_locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wm_plant_emulator.md
Name: wm_plant_emulator

Overview:
- Synthesizable model of the washing-machine appliance (drum, water circuit, heater, motor, door latch). It is the sensor-producing counterpart of the washing machine controller.
- Consumes the controller's actuator commands (water_valve, heater, drain_pump, drum_motor, door_lock).
- Produces the sensor values the controller reads (water_level_sensor, temperature_adc_sensor, motor_speed_sensor, vibration_sensor, door_locked).
- Used for closed-loop simulation and FPGA hardware-in-loop; all physics advance on a prescaled tick.

Parameters:
TICK_DIV, 16'd4, clk cycles per physics tick (>=1)
FILL_RATE, 10'd8, level units added per tick while valve open
DRAIN_RATE, 10'd12, level units removed per tick while pump on
MAX_LEVEL, 10'd1000, drum full level; level saturates here
MIN_HEAT_LEVEL, 10'd80, minimum level for heater to take effect
HEAT_DIV, 8'd3, ticks per +1 degC while heating
COOL_DIV, 8'd20, ticks per -1 degC while not heating
AMBIENT_TEMP, 7'd15, ambient/inlet water temperature degC
TEMP_MAX, 7'd95, temperature ceiling
MOTOR_ACCEL, 10'd20, speed units gained per tick with motor on
MOTOR_DECEL, 10'd10, speed units lost per tick with motor off
MOTOR_MAX, 10'd700, speed ceiling (1 unit = 2 rpm)
VIB_SPEED, 10'd300, speed at/above which imbalance produces vibration
LOCK_DELAY, 8'd5, ticks for door latch to engage/release

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
water_valve  in  1  inlet valve command
heater  in  1  heater command
drain_pump  in  1  drain pump command
drum_motor  in  1  drum motor command
door_lock  in  1  latch request (1 = lock)
imbalance_inject  in  1  fault injection: unbalanced load
sensor_freeze  in  1  fault injection: hold all sensor outputs
water_level_sensor  out  10  current water level
temperature_adc_sensor  out  7  water temperature degC
motor_speed_sensor  out  10  drum speed
vibration_sensor  out  1  excessive vibration
door_locked  out  1  latch engaged
overflow_flag  out  1  valve open while level == MAX_LEVEL (sticky)
dry_heat_fault  out  1  heater on with level < MIN_HEAT_LEVEL (sticky)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high, sampled on posedge clk.
- Reset values:
  - level = 0; temp = AMBIENT_TEMP; speed = 0.
  - vibration_sensor = 0; door_locked = 0; both fault flags = 0.
  - Prescaler, heat/cool counters and lock counter = 0; door FSM = UNLOCKED.
  - Reset mid-operation aborts everything to these values on the next edge.
- Tick generation:
  - Prescaler counts 0..TICK_DIV-1; tick = 1 for the single cycle when count == TICK_DIV-1, then it wraps.
  - All state below updates only on tick cycles. Commands are sampled in that same cycle.
  - Outputs change the cycle after the tick edge, i.e. they are registered.
- Water level (11-bit signed intermediate, then clamp to [0, MAX_LEVEL]):
  - Valve only: +FILL_RATE. Pump only: -DRAIN_RATE. Both: +FILL_RATE-DRAIN_RATE. Neither: hold.
  - overflow_flag sets when water_valve = 1 on a tick with level == MAX_LEVEL.
- Temperature:
  - If heater = 1 and level >= MIN_HEAT_LEVEL: heat counter increments per tick; at HEAT_DIV-1 it clears and temp += 1, saturating at TEMP_MAX. Cool counter is cleared.
  - Otherwise the cool counter runs; at COOL_DIV-1 it clears and temp -= 1, never below AMBIENT_TEMP. Heat counter is cleared.
  - Level reaching 0 on a tick forces temp = AMBIENT_TEMP and clears both counters.
  - dry_heat_fault sets when heater = 1 on a tick with level < MIN_HEAT_LEVEL. Temperature does not rise in that case.
- Motor:
  - drum_motor = 1 and door_locked = 1: speed += MOTOR_ACCEL, saturating at MOTOR_MAX.
  - Otherwise: speed -= MOTOR_DECEL, saturating at 0.
  - The motor never accelerates with the door unlocked.
- Vibration: vibration_sensor = imbalance_inject AND (speed >= VIB_SPEED), registered on each tick.
- Door FSM:
  - UNLOCKED -> LOCKING when door_lock = 1.
  - LOCKING: the lock counter counts ticks. At LOCK_DELAY it goes to LOCKED (door_locked = 1). If door_lock drops first, it returns to UNLOCKED and the counter clears.
  - LOCKED -> UNLOCKING when door_lock = 0 and speed == 0 and level == 0. The safety interlock holds LOCKED otherwise, regardless of the request.
  - UNLOCKING: after LOCK_DELAY ticks -> UNLOCKED (door_locked = 0). If door_lock = 1 reasserts, it returns to LOCKED.
  - door_locked = 1 only in LOCKED and UNLOCKING.
- sensor_freeze = 1:
  - Output registers hold their values.
  - Internal level/temp/speed/door state keep evolving.
  - On release, outputs show current internal values on the next tick.
- Fault flags clear only on reset.

Test Plan:
- Reset, TICK_DIV = 4, water_valve = 1 for 40 cycles (10 ticks) -> water_level_sensor = 80. Then 125+ ticks -> saturates at 1000 and overflow_flag = 1.
- Level 1000, drain_pump = 1 for 84 ticks -> level 0 (clamped, no wrap). temperature_adc_sensor returns to 15 on the tick level reaches 0.
- Level 200, heater = 1 for 30 ticks -> temp 25. heater = 1 with level 50 -> dry_heat_fault = 1 and temp unchanged.
- door_lock = 1 -> door_locked = 1 after 5 ticks. drum_motor = 1 for 35 ticks -> speed 700. door_lock = 0 with speed > 0 -> door_locked stays 1 until speed reaches 0, then releases 5 ticks later.
- drum_motor = 1, door unlocked -> speed stays 0. Locked, imbalance_inject = 1 -> vibration_sensor rises on the first tick with speed >= 300 (15th tick).
- sensor_freeze = 1 during filling -> level output constant while internal level rises. Release -> jumps to the internal value on the next tick. reset asserted mid-fill -> all outputs at reset values on the next cycle.
